// File: rtl/fpmul_pkg.sv
// Shared constants and stage-3 payload record for the single-precision
// multiplier pipeline.
package fpmul_pkg;

  localparam int EXP_W  = 8;
  localparam int SIG_W  = 28;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  INF_EXP = 8'hFF;

  // Extended exponents at or above this value no longer fit a finite result.
  localparam logic signed [9:0] E_OVF = 10'(2 * BIAS + 1);

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic              inc;
    logic signed [9:0] e;
    logic              sign;
    logic              is_nan;
    logic              is_inf;
    logic              is_z;
  } s3_payload_t;

endpackage

// File: rtl/fpmul_rne_round.sv
// Combinational single-bit normalise plus guard/sticky extraction and
// round-to-nearest-even increment decision.
module fpmul_rne_round
  import fpmul_pkg::*;
(
  input  logic [SIG_W-1:0]  sig,
  output logic [MANT_W-1:0] mant,
  output logic              inc,
  output logic              nshift
);

  logic guard_s;
  logic sticky_s;

  // Select the mantissa window according to the integer-part MSB.
  always_comb begin
    mant     = '0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    nshift   = 1'b0;
    if (sig[27]) begin
      mant     = sig[26:4];
      guard_s  = sig[3];
      sticky_s = |sig[2:0];
      nshift   = 1'b1;
    end else begin
      mant     = sig[25:3];
      guard_s  = sig[2];
      sticky_s = |sig[1:0];
      nshift   = 1'b0;
    end
    inc = guard_s & (sticky_s | mant[0]);
  end

endmodule

// File: rtl/fpmul_stage3_round.sv
// Multiplier stage 3/4: normalise and RNE-round the stage-2 product, then
// resolve specials/overflow/underflow and pack FP_Z behind a 2-deep pipeline.
module fpmul_stage3_round
  import fpmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  EXP_in,
  input  logic [SIG_W-1:0]  SIG_in,
  input  logic              EXP_pos_stage2,
  input  logic              EXP_neg_stage2,
  input  logic              SIGN_out_stage2,
  input  logic              isINF_stage2,
  input  logic              isNaN_stage2,
  input  logic              isZ_tab_stage2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       FP_Z,
  output logic              OVF_out,
  output logic              UNF_out
);

  logic              v3_r;
  logic              v4_r;
  s3_payload_t       s3_r;
  s3_payload_t       s3_nxt_s;
  logic              ready3_s;
  logic              ready4_s;
  logic [MANT_W-1:0] mant_s;
  logic              inc_s;
  logic              nshift_s;
  logic signed [9:0] e_base_s;
  logic [24:0]       m24_s;
  logic signed [9:0] e4_s;
  logic [31:0]       fpz_nxt_s;
  logic              ovf_nxt_s;
  logic              unf_nxt_s;
  logic [31:0]       fpz_r;
  logic              ovf_r;
  logic              unf_r;

  assign ready4_s  = ~v4_r | out_ready;
  assign ready3_s  = ~v3_r | ready4_s;
  assign in_ready  = ready3_s;
  assign out_valid = v4_r;
  assign FP_Z      = fpz_r;
  assign OVF_out   = ovf_r;
  assign UNF_out   = unf_r;

  fpmul_rne_round u_rne (
    .sig    (SIG_in),
    .mant   (mant_s),
    .inc    (inc_s),
    .nshift (nshift_s)
  );

  // Recover the true exponent range lost to the 8-bit mod-256 sum upstream.
  always_comb begin
    e_base_s = 10'sd0;
    if (EXP_pos_stage2 & ~EXP_in[7]) begin
      e_base_s = 10'sd256;
    end else if (EXP_neg_stage2 & EXP_in[7]) begin
      e_base_s = -10'sd256;
    end else begin
      e_base_s = 10'sd0;
    end
    s3_nxt_s.mant   = mant_s;
    s3_nxt_s.inc    = inc_s;
    s3_nxt_s.e      = e_base_s + $signed({2'b00, EXP_in}) + $signed({9'd0, nshift_s});
    s3_nxt_s.sign   = SIGN_out_stage2;
    s3_nxt_s.is_nan = isNaN_stage2;
    s3_nxt_s.is_inf = isINF_stage2;
    s3_nxt_s.is_z   = isZ_tab_stage2;
  end

  // Stage-3 register: advances whenever it is empty or stage 4 can take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r <= 1'b0;
      s3_r <= '0;
    end else if (ready3_s) begin
      v3_r <= in_valid;
      if (in_valid) begin
        s3_r <= s3_nxt_s;
      end
    end
  end

  // Apply the rounding increment and pick the result by special-case priority.
  always_comb begin
    m24_s     = {2'b01, s3_r.mant} + {24'd0, s3_r.inc};
    e4_s      = s3_r.e + $signed({9'd0, m24_s[24]});
    fpz_nxt_s = {s3_r.sign, e4_s[7:0], m24_s[22:0]};
    ovf_nxt_s = 1'b0;
    unf_nxt_s = 1'b0;
    if (s3_r.is_nan) begin
      fpz_nxt_s = QNAN;
    end else if (s3_r.is_inf) begin
      fpz_nxt_s = {s3_r.sign, INF_EXP, 23'd0};
    end else if (s3_r.is_z) begin
      fpz_nxt_s = {s3_r.sign, 31'd0};
    end else if (e4_s >= E_OVF) begin
      fpz_nxt_s = {s3_r.sign, INF_EXP, 23'd0};
      ovf_nxt_s = 1'b1;
    end else if (e4_s <= 10'sd0) begin
      fpz_nxt_s = {s3_r.sign, 31'd0};
      unf_nxt_s = 1'b1;
    end else begin
      fpz_nxt_s = {s3_r.sign, e4_s[7:0], m24_s[22:0]};
    end
  end

  // Output register: holds FP_Z stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v4_r  <= 1'b0;
      fpz_r <= 32'd0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (ready4_s) begin
      v4_r <= v3_r;
      if (v3_r) begin
        fpz_r <= fpz_nxt_s;
        ovf_r <= ovf_nxt_s;
        unf_r <= unf_nxt_s;
      end
    end
  end

endmodule
